// File: rtl/bcd_result_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_result_display_if
//  Description : Result handshake and BCD result bundle between the calculator
//                core (master) and the BCD conversion/display block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_result_display_if #(
    parameter int WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_signed;
    logic             out_valid;
    logic [15:0]      bcd;
    logic             neg;
    logic             overflow;

    modport master (
        output in_valid, in_data, in_signed,
        input  in_ready, out_valid, bcd, neg, overflow
    );

    modport slave (
        input  in_valid, in_data, in_signed,
        output in_ready, out_valid, bcd, neg, overflow
    );
endinterface
`default_nettype wire

// File: rtl/bcd_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_result_display
//  Description : Sequential double-dabble conversion of a binary calculator
//                result into 4 BCD digits plus sign/overflow, and a
//                time-multiplexed 4-digit 7-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_result_display #(
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 1024
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    bcd_result_display_if.slave bus,
    output logic [3:0]          an,
    output logic [6:0]          seg
);
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    localparam logic [CNT_W-1:0]  C_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [SCAN_W-1:0] C_SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [6:0] C_SEG_DASH  = 7'h40;
    localparam logic [6:0] C_SEG_BLANK = 7'h00;
    localparam logic [6:0] C_SEG_ZERO  = 7'h3F;

    // Standard 7-segment glyphs {g,f,e,d,c,b,a}; codes 10..15 never reach here
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = C_SEG_BLANK;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              signed_q, signed_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [19:0]       work_q, work_d;
    logic              neg_w_q, neg_w_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [19:0]       adj_work;
    logic [19:0]       step_work;
    logic [WIDTH-1:0]  step_mag;
    logic              scan_wrap;
    logic [1:0]        msd;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: capture, one load cycle, WIDTH shift steps, one done cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == C_LAST_STEP) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and the result bundle
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.bcd       = bcd_q;
        bus.neg       = neg_q;
        bus.overflow  = ovf_q;
        an            = an_q;
        seg           = seg_q;
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {work,mag} left
    always_comb begin
        adj_work = work_q;
        for (int i = 0; i < 5; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj_work[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        {step_work, step_mag} = {adj_work, mag_q} << 1;
    end

    // Datapath next values; result registers load on the final shift step
    always_comb begin
        data_d   = data_q;
        signed_d = signed_q;
        mag_d    = mag_q;
        work_d   = work_q;
        neg_w_d  = neg_w_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d   = bus.in_data;
                    signed_d = bus.in_signed;
                end
            end
            S_LOAD: begin
                if (signed_q && data_q[WIDTH-1]) begin
                    mag_d   = -data_q;
                    neg_w_d = 1'b1;
                end else begin
                    mag_d   = data_q;
                    neg_w_d = 1'b0;
                end
                work_d = '0;
                cnt_d  = '0;
            end
            S_SHIFT: begin
                work_d = step_work;
                mag_d  = step_mag;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_STEP) begin
                    if (step_work[19:16] != 4'd0) begin
                        // Beyond 9999 the four digits are meaningless; show a clean overflow
                        bcd_d = '0;
                        neg_d = 1'b0;
                        ovf_d = 1'b1;
                    end else begin
                        bcd_d = step_work[15:0];
                        neg_d = neg_w_q && (step_work[15:0] != 16'd0);
                        ovf_d = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            signed_q <= 1'b0;
            mag_q    <= '0;
            work_q   <= '0;
            neg_w_q  <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            signed_q <= signed_d;
            mag_q    <= mag_d;
            work_q   <= work_d;
            neg_w_q  <= neg_w_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    // Display scan; segments derive from the next result values so that the
    // glyphs change in the same edge as the result registers
    always_comb begin
        scan_wrap  = (scan_cnt_q == C_SCAN_LAST);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
        an_d       = 4'b0001 << idx_d;
        if      (bcd_d[15:12] != 4'd0) msd = 2'd3;
        else if (bcd_d[11:8]  != 4'd0) msd = 2'd2;
        else if (bcd_d[7:4]   != 4'd0) msd = 2'd1;
        else                           msd = 2'd0;
        if (ovf_d)
            seg_d = C_SEG_DASH;
        else if (idx_d <= msd)
            seg_d = glyph(bcd_d[{idx_d, 2'b00} +: 4]);
        else if (neg_d && ({1'b0, idx_d} == ({1'b0, msd} + 3'd1)))
            seg_d = C_SEG_DASH;
        else
            seg_d = C_SEG_BLANK;
    end

    // Display registers: an and seg advance together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b0001;
            seg_q      <= C_SEG_ZERO;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bcd_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_result_display
//  Description : Self-checking bench for bcd_result_display: vector table,
//                hand-written timing/reset sequences and random results
//                against a decimal-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_result_display;
    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;

    bcd_result_display_if #(.WIDTH(WIDTH)) bus ();

    bcd_result_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [13:0]     data;
        logic            sgn;
        logic [15:0]     bcd;
        logic            neg;
        logic            ovf;
        logic [3:0][6:0] segs;   // segs[i] is what an[i] must show
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] tb_glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference: integer value -> decimal digits, sign and display contents
    function automatic void model(input logic [13:0] d, input logic s,
                                  output logic [15:0] b, output logic n, output logic o,
                                  output logic [3:0][6:0] sg, output logic fits);
        int mag;
        int ndig;
        int dig [4];
        bit was_neg;
        if (s && d[13]) begin mag = 16384 - int'(d); was_neg = 1'b1; end
        else            begin mag = int'(d);         was_neg = 1'b0; end
        fits = 1'b1;
        if (mag > 9999) begin
            o = 1'b1; b = 16'h0; n = 1'b0;
            for (int i = 0; i < 4; i++) sg[i] = 7'h40;
        end else begin
            o = 1'b0;
            n = was_neg && (mag != 0);
            dig[0] = mag % 10; dig[1] = (mag / 10) % 10;
            dig[2] = (mag / 100) % 10; dig[3] = mag / 1000;
            b = {4'(dig[3]), 4'(dig[2]), 4'(dig[1]), 4'(dig[0])};
            ndig = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
            for (int i = 0; i < 4; i++) begin
                if (i < ndig)            sg[i] = tb_glyph(dig[i]);
                else if (n && i == ndig) sg[i] = 7'h40;
                else                     sg[i] = 7'h00;
            end
            if (n && ndig == 4) fits = 1'b0;
        end
    endfunction

    // Drive one result from IDLE and check handshake timing up to the pulse end
    task automatic convert(input logic [13:0] d, input logic s, input string tag);
        int edges = 0;
        int busy  = 0;
        check({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        @(posedge clk); #1;                 // accept edge
        bus.in_valid  = 1'b0;
        bus.in_data   = 14'($urandom);      // must already be captured
        bus.in_signed = 1'($urandom);
        while (!bus.out_valid && edges < 40) begin
            if (!bus.in_ready) busy++;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(WIDTH + 1));
        if (!bus.in_ready) busy++;          // DONE cycle
        check({tag, "_busy_cycles"}, 32'(busy), 32'(WIDTH + 2));
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    // Watch a full scan rotation and compare each lit digit
    task automatic check_display(input logic [3:0][6:0] exp, input string tag);
        int idx;
        for (int k = 0; k < 4 * SCAN_DIV; k++) begin
            @(posedge clk); #1;
            check({tag, "_an_onehot"}, 32'($onehot(an)), 32'd1);
            idx = an[0] ? 0 : an[1] ? 1 : an[2] ? 2 : 3;
            check({tag, "_seg"}, 32'(seg), 32'(exp[idx]));
        end
    endtask

    // After reset release the scan starts at digit 0 and advances every SCAN_DIV edges
    task automatic check_scan_from_reset(input string tag);
        int pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
            check({tag, "_an_seq"}, 32'(an), 32'(4'b0001 << ((k / SCAN_DIV) % 4)));
        end
        check({tag, "_no_valid"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [15:0]     mb;
        logic            mn, mo, mf;
        logic [3:0][6:0] ms;
        logic [13:0]     rd;
        logic            rs;
        int              e, p1, p2;
        logic [15:0]     b1, b2;

        tbl[0] = '{14'd9801,  1'b0, 16'h9801, 1'b0, 1'b0, {7'h6F, 7'h7F, 7'h3F, 7'h06}};
        tbl[1] = '{14'h3FF7,  1'b1, 16'h0009, 1'b1, 1'b0, {7'h00, 7'h00, 7'h40, 7'h6F}};
        tbl[2] = '{14'h3FF7,  1'b0, 16'h0000, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[3] = '{14'd0,     1'b1, 16'h0000, 1'b0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h3F}};
        tbl[4] = '{14'd99,    1'b0, 16'h0099, 1'b0, 1'b0, {7'h00, 7'h00, 7'h6F, 7'h6F}};
        tbl[5] = '{14'd12,    1'b0, 16'h0012, 1'b0, 1'b0, {7'h00, 7'h00, 7'h06, 7'h5B}};
        tbl[6] = '{14'd9999,  1'b0, 16'h9999, 1'b0, 1'b0, {7'h6F, 7'h6F, 7'h6F, 7'h6F}};
        tbl[7] = '{14'd10000, 1'b0, 16'h0000, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[8] = '{14'h3FFF,  1'b1, 16'h0001, 1'b1, 1'b0, {7'h00, 7'h00, 7'h40, 7'h06}};
        tbl[9] = '{14'h3F9D,  1'b1, 16'h0099, 1'b1, 1'b0, {7'h00, 7'h40, 7'h6F, 7'h6F}};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",    32'(bus.in_ready),  32'd1);
        check("rst_valid",    32'(bus.out_valid), 32'd0);
        check("rst_bcd",      32'(bus.bcd),       32'd0);
        check("rst_neg",      32'(bus.neg),       32'd0);
        check("rst_overflow", 32'(bus.overflow),  32'd0);
        check("rst_an",       32'(an),            32'b0001);
        check("rst_seg",      32'(seg),           32'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        check_scan_from_reset("init");

        // Table vectors (entries 4 and 5 run back to back: 99 then 12)
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            convert(tbl[i].data, tbl[i].sgn, tag);
            check({tag, "_bcd"}, 32'(bus.bcd),      32'(tbl[i].bcd));
            check({tag, "_neg"}, 32'(bus.neg),      32'(tbl[i].neg));
            check({tag, "_ovf"}, 32'(bus.overflow), 32'(tbl[i].ovf));
            check_display(tbl[i].segs, tag);
        end

        // in_valid held high: 42 then 7. Each result needs one IDLE cycle plus
        // sixteen busy cycles, so the pulses land WIDTH+3 edges apart.
        check("held_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 14'd42;
        bus.in_signed = 1'b0;
        @(posedge clk); #1;
        bus.in_data = 14'd7;
        e = 0; p1 = -1; p2 = -1; b1 = '0; b2 = '0;
        while (p2 < 0 && e < 60) begin
            @(posedge clk); #1;
            e++;
            if (bus.out_valid) begin
                if (p1 < 0) begin p1 = e; b1 = bus.bcd; end
                else begin p2 = e; b2 = bus.bcd; bus.in_valid = 1'b0; end
            end
        end
        check("held_first_latency", 32'(p1),      32'(WIDTH + 1));
        check("held_pulse_gap",     32'(p2 - p1), 32'(WIDTH + 3));
        check("held_first_bcd",     32'(b1),      32'h0042);
        check("held_second_bcd",    32'(b2),      32'h0007);
        @(posedge clk); #1;
        check("held_idle_after", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of the shift sequence
        convert(14'd555, 1'b0, "pre_rst");
        check("pre_rst_bcd", 32'(bus.bcd), 32'h0555);
        bus.in_valid  = 1'b1;
        bus.in_data   = 14'd9876;
        bus.in_signed = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);          // LOAD, then shift steps 1..5
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.in_ready),  32'd1);
        check("midrst_bcd",   32'(bus.bcd),       32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_an",    32'(an),            32'b0001);
        check("midrst_seg",   32'(seg),           32'h3F);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_scan_from_reset("midrst");
        convert(14'd123, 1'b0, "post_rst");
        check("post_rst_bcd", 32'(bus.bcd), 32'h0123);
        check("post_rst_neg", 32'(bus.neg), 32'd0);

        // Random results against the reference model
        for (int i = 0; i < 40; i++) begin
            string tag;
            tag = $sformatf("rnd%0d", i);
            if ($urandom_range(0, 3) == 0) begin
                rd = 14'($signed($urandom_range(0, 198)) - 99);
                rs = 1'b1;
            end else begin
                rd = 14'($urandom);
                rs = 1'($urandom);
            end
            model(rd, rs, mb, mn, mo, ms, mf);
            convert(rd, rs, tag);
            check({tag, "_bcd"}, 32'(bus.bcd),      32'(mb));
            check({tag, "_neg"}, 32'(bus.neg),      32'(mn));
            check({tag, "_ovf"}, 32'(bus.overflow), 32'(mo));
            if (mf) check_display(ms, tag);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
